vector_lsu: RTL and testbench
=============================

# vector_lsu

Vector load/store sequencer that is the initiator side of the 3-port `dataMemory`. It accepts one vector memory command, splits it into beats of up to three 16-bit element accesses, and drives `pos1..3`, `WD1..3`, `OE` and `wEnable`. For loads it collects `RD1..3` into a result vector. It sits between the vector execute stage and `dataMemory`.

## Interface
Parameters:
- `NUM_LANES`, default 8: elements per vector; must be between 1 and 16.
- `MEM_RD_LAT`, default 1: cycles from driving `OE` and address to `RD*` being valid; allowed values are 1 or 2.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: command request; sampled only in IDLE.
- `is_store`  in  1: 1 selects store, 0 selects load.
- `base`  in  16: byte-free element address of element 0.
- `stride`  in  16: address increment between elements; used only with `VLSU_STRIDE_EN`.
- `count`  in  5: number of elements to move; values above `NUM_LANES` are clamped to `NUM_LANES`.
- `st_data`  in  16*NUM_LANES: store vector; lane i occupies bits [16i+15:16i].
- `busy`  out  1: a command is in progress.
- `done`  out  1: one-cycle completion pulse.
- `ld_data`  out  16*NUM_LANES: load result vector.
- `pos1`, `pos2`, `pos3`  out  16 each: memory addresses.
- `WD1`, `WD2`, `WD3`  out  16 each: memory write data.
- `OE`  out  1: memory read enable.
- `wEnable`  out  1: memory write enable, shared by all three ports.
- `RD1`, `RD2`, `RD3`  in  16 each: memory read data.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - When `start`=1, latch `base`, `stride`, clamped `count`, `is_store` and `st_data`.
  - Go to ISSUE. If clamped count=0, go straight to DONE.
- **ISSUE:**
  - One beat per cycle. Beat b covers lanes 3b, 3b+1 and 3b+2.
  - Address of lane i = base + i*stride, computed mod 2^16 (wraps silently).
  - Store beat: `wEnable`=1, `OE`=0, `WDk` = lane data.
  - Load beat: `OE`=1, `wEnable`=0.
  - Beats total ceil(count/3).
  - Port slots past the last valid lane in the final beat duplicate the last valid lane's address and data. The duplicated write is idempotent, so the shared `wEnable` is safe.
  - After the last beat, stores go to DONE. Loads go to DRAIN, or to DONE once all captures are complete.
- **DRAIN:** wait until the final beat's data has been captured.
- **Load capture:** `RD1..3` for beat b are written into lanes 3b..3b+2 of `ld_data` exactly `MEM_RD_LAT` cycles after that beat is issued. Duplicate slots are discarded.
- **DONE:**
  - `done`=1 for one cycle, `busy`=0, then return to IDLE.
  - `ld_data` holds its value until the next accepted load's first capture.
  - Lanes at index ≥ count retain their prior contents.
- **Idle outputs:** whenever not in ISSUE, `OE`=0 and `wEnable`=0. `pos*` and `WD*` hold their last values.
- **Reset:** `reset_n`=0 at any point, including mid-command, takes effect at the next edge. The command is abandoned with no further memory access and no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `OE`=0, `wEnable`=0, `pos1..3`=0, `WD1..3`=0, `ld_data`=0; state is IDLE.
- `start` is sampled in cycle T.
  - `busy`=1 from T+1.
  - The first beat is driven in T+1.
- Store with B beats: beats occupy T+1..T+B; `done` pulses at T+B+1.
- Load with B beats: `done` pulses at T+B+MEM_RD_LAT+1, with `ld_data` fully valid in that same cycle.
- count=0: `done` pulses at T+1 with no memory activity.
- `start` is ignored while `busy`=1.
- `start` asserted in the `done` cycle is ignored; it is accepted once the block is back in IDLE, one cycle later.
- Outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `VLSU_STRIDE_EN` defined: `stride` input is honoured.
- `VLSU_STRIDE_EN` undefined:
  - `stride` is ignored and the stride is fixed at 1 (unit stride).
  - The stride multiplier logic is removed; addresses come from an incrementer.

## Test plan
- **Reset mid-command:** store count=8, then `reset_n`=0 at beat 2 → no further `wEnable` pulses, no `done`, all outputs return to reset values.
- **Unit-stride store:** base=0x0000, count=8, `st_data` lanes 0x0001..0x0008 → three `wEnable` beats:
  - beat 0: pos=(0,1,2);
  - beat 1: pos=(3,4,5);
  - beat 2: pos=(6,7,7) with WD3=0x0008;
  - `done` at T+4.
- **Load-back:** load base=0, count=8, MEM_RD_LAT=1, after the store above → `ld_data` lanes = 0x0001..0x0008, `done` at T+5, `OE` high only in T+1..T+3.
- **Strided wrap (`VLSU_STRIDE_EN`):** base=0xFFFE, stride=4, count=3 → pos=(0xFFFE,0x0002,0x0006) in a single beat.
- **count=0 and clamping:**
  - count=0 → `done` at T+1, `OE`/`wEnable` never asserted;
  - count=20 with NUM_LANES=8 → exactly 3 beats.
- **Back-to-back:** `start` held high continuously → second command accepted only in IDLE, one cycle after `done`; `start` during `busy` has no effect.

Source files
------------

// File: rtl/vector_lsu.sv
// vector_lsu: initiator-side load/store sequencer for the 3-port dataMemory.
// A single vector command is split into beats of up to three 16-bit element
// accesses. Load data returning MEM_RD_LAT cycles later is gathered into ld_data.
// Optional feature macro: VLSU_STRIDE_EN. When it is defined, the stride input
// is honoured. Otherwise the stride is fixed at 1 and addresses come from an
// incrementer.
module vector_lsu #(
  parameter int NUM_LANES  = 8,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [15:0]             base,
  input  logic [15:0]             stride,
  input  logic [4:0]              count,
  input  logic [16*NUM_LANES-1:0] st_data,
  output logic                    busy,
  output logic                    done,
  output logic [16*NUM_LANES-1:0] ld_data,
  output logic [15:0]             pos1,
  output logic [15:0]             pos2,
  output logic [15:0]             pos3,
  output logic [15:0]             WD1,
  output logic [15:0]             WD2,
  output logic [15:0]             WD3,
  output logic                    OE,
  output logic                    wEnable,
  input  logic [15:0]             RD1,
  input  logic [15:0]             RD2,
  input  logic [15:0]             RD3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LANES5 = 5'(NUM_LANES);
  localparam int         CAP    = MEM_RD_LAT - 1;

  // Returns the 16-bit word of lane idx. A lane index past the vector returns zero.
  function automatic logic [15:0] lane_word(input logic [16*NUM_LANES-1:0] vec,
                                            input logic [5:0]              idx);
    logic [15:0] w;
    w = 16'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w = (idx == 6'(i)) ? vec[16*i +: 16] : w;
    end
    return w;
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;

  // Latched command
  logic [4:0]              cnt_r;
  logic                    is_store_r;
  logic [16*NUM_LANES-1:0] st_data_r;

  // Beat bookkeeping: lane_r and nv_r describe the beat currently on the pins
  logic [15:0]             next_addr_r;
  logic [5:0]              lane_r;
  logic [1:0]              nv_r;

  // Capture pipeline that tracks each load beat until its read data returns
  logic                    cap_vld_r  [MEM_RD_LAT];
  logic [5:0]              cap_lane_r [MEM_RD_LAT];
  logic [1:0]              cap_n_r    [MEM_RD_LAT];
  logic                    cap_last_r [MEM_RD_LAT];

  logic                    idle_s;
  logic [4:0]              clamped_s;
  logic [15:0]             src_addr_s;
  logic [4:0]              src_cnt_s;
  logic                    src_store_s;
  logic [16*NUM_LANES-1:0] src_data_s;
  logic [5:0]              src_lane_s;
  logic [5:0]              rem_s;
  logic [5:0]              cur_rem_s;
  logic [1:0]              nv_s;
  logic                    last_s;
  logic                    issue_s;
  logic                    drain_done_s;
  logic [15:0]             a0_s, a1_s, a2_s, adv_s;
  logic [15:0]             d0_s, d1_s, d2_s;
  logic [15:0]             slot1_addr_s, slot2_addr_s, slot3_addr_s;
  logic [15:0]             slot1_data_s, slot2_data_s, slot3_data_s;
  logic [5:0]              cap_off_s  [NUM_LANES];
  logic                    cap_we_s   [NUM_LANES];
  logic [15:0]             cap_word_s [NUM_LANES];

`ifdef VLSU_STRIDE_EN
  logic [15:0]             stride_r;
  logic [15:0]             step_s;
`else
  logic                    unused_stride_s;
  assign unused_stride_s = ^stride;
`endif

  assign idle_s       = (state_r == IDLE);
  assign clamped_s    = (count > LANES5) ? LANES5 : count;
  assign cur_rem_s    = {1'b0, cnt_r} - lane_r;
  assign last_s       = (cur_rem_s <= 6'd3);
  assign drain_done_s = cap_vld_r[CAP] && cap_last_r[CAP];

  // Source of the next beat: the live inputs when starting, else the latched command
  always_comb begin
    if (idle_s) begin
      src_addr_s  = base;
      src_cnt_s   = clamped_s;
      src_store_s = is_store;
      src_data_s  = st_data;
      src_lane_s  = 6'd0;
    end else begin
      src_addr_s  = next_addr_r;
      src_cnt_s   = cnt_r;
      src_store_s = is_store_r;
      src_data_s  = st_data_r;
      src_lane_s  = lane_r + 6'd3;
    end
  end

`ifdef VLSU_STRIDE_EN
  // Strided slot addresses built from stride and 2*stride; mod-2^16 wrap is intended
  always_comb begin
    if (idle_s) begin
      step_s = stride;
    end else begin
      step_s = stride_r;
    end
    a0_s  = src_addr_s;
    a1_s  = src_addr_s + step_s;
    a2_s  = src_addr_s + {step_s[14:0], 1'b0};
    adv_s = a2_s + step_s;
  end
`else
  // Unit-stride slot addresses taken from a plain incrementer
  always_comb begin
    a0_s  = src_addr_s;
    a1_s  = src_addr_s + 16'd1;
    a2_s  = src_addr_s + 16'd2;
    adv_s = src_addr_s + 16'd3;
  end
`endif

  // Slot data and the duplication of the last valid lane into unused slots
  always_comb begin
    rem_s = {1'b0, src_cnt_s} - src_lane_s;
    nv_s  = (rem_s >= 6'd3) ? 2'd3 : rem_s[1:0];
    d0_s  = lane_word(src_data_s, src_lane_s);
    d1_s  = lane_word(src_data_s, src_lane_s + 6'd1);
    d2_s  = lane_word(src_data_s, src_lane_s + 6'd2);
    slot1_addr_s = a0_s;
    slot1_data_s = d0_s;
    if (nv_s >= 2'd2) begin
      slot2_addr_s = a1_s;
      slot2_data_s = d1_s;
    end else begin
      slot2_addr_s = a0_s;
      slot2_data_s = d0_s;
    end
    if (nv_s == 2'd3) begin
      slot3_addr_s = a2_s;
      slot3_data_s = d2_s;
    end else begin
      slot3_addr_s = slot2_addr_s;
      slot3_data_s = slot2_data_s;
    end
  end

  // Next-state logic; issue_s marks that a beat is loaded onto the pins this edge
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (clamped_s == 5'd0) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ISSUE;
            issue_s      = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_s) begin
          state_next_s = is_store_r ? DONE : DRAIN;
        end else begin
          state_next_s = ISSUE;
          issue_s      = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latch the command when it is accepted in IDLE
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r      <= 5'd0;
      is_store_r <= 1'b0;
      st_data_r  <= '0;
    end else if (idle_s && start) begin
      cnt_r      <= clamped_s;
      is_store_r <= is_store;
      st_data_r  <= st_data;
    end
  end

`ifdef VLSU_STRIDE_EN
  // Latch the stride with the command
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stride_r <= 16'd0;
    end else if (idle_s && start) begin
      stride_r <= stride;
    end
  end
`endif

  // Registered memory-side outputs; addresses and data hold between beats
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      OE          <= 1'b0;
      wEnable     <= 1'b0;
      pos1        <= 16'd0;
      pos2        <= 16'd0;
      pos3        <= 16'd0;
      WD1         <= 16'd0;
      WD2         <= 16'd0;
      WD3         <= 16'd0;
      next_addr_r <= 16'd0;
      lane_r      <= 6'd0;
      nv_r        <= 2'd0;
    end else begin
      OE      <= issue_s & ~src_store_s;
      wEnable <= issue_s & src_store_s;
      if (issue_s) begin
        pos1        <= slot1_addr_s;
        pos2        <= slot2_addr_s;
        pos3        <= slot3_addr_s;
        WD1         <= slot1_data_s;
        WD2         <= slot2_data_s;
        WD3         <= slot3_data_s;
        next_addr_r <= adv_s;
        lane_r      <= src_lane_s;
        nv_r        <= nv_s;
      end
    end
  end

  // Registered status outputs derived from the next state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next_s == ISSUE) || (state_next_s == DRAIN);
      done <= (state_next_s == DONE);
    end
  end

  // Delay each load beat's descriptor so it meets its read data
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int j = 0; j < MEM_RD_LAT; j++) begin
        cap_vld_r[j]  <= 1'b0;
        cap_lane_r[j] <= 6'd0;
        cap_n_r[j]    <= 2'd0;
        cap_last_r[j] <= 1'b0;
      end
    end else begin
      cap_vld_r[0]  <= OE;
      cap_lane_r[0] <= lane_r;
      cap_n_r[0]    <= nv_r;
      cap_last_r[0] <= last_s;
      for (int j = 1; j < MEM_RD_LAT; j++) begin
        cap_vld_r[j]  <= cap_vld_r[j-1];
        cap_lane_r[j] <= cap_lane_r[j-1];
        cap_n_r[j]    <= cap_n_r[j-1];
        cap_last_r[j] <= cap_last_r[j-1];
      end
    end
  end

  // Map the returning RD ports onto lanes; duplicate slots get no write enable
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      cap_off_s[i] = 6'(i) - cap_lane_r[CAP];
      cap_we_s[i]  = cap_vld_r[CAP] && (6'(i) >= cap_lane_r[CAP]) &&
                     (cap_off_s[i] < {4'd0, cap_n_r[CAP]});
      case (cap_off_s[i][1:0])
        2'd0:    cap_word_s[i] = RD1;
        2'd1:    cap_word_s[i] = RD2;
        default: cap_word_s[i] = RD3;
      endcase
    end
  end

  // Load result register; lanes not written keep their previous contents
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ld_data <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (cap_we_s[i]) begin
          ld_data[16*i +: 16] <= cap_word_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed testbench for vector_lsu (NUM_LANES=8, MEM_RD_LAT=1) with a simple
// 3-port memory model. It honours VLSU_STRIDE_EN for the strided-wrap case.
module tb_vector_lsu;

  localparam int NL = 8;
  localparam int LAT = 1;
  localparam logic [127:0] DATA8 = {16'h0008, 16'h0007, 16'h0006, 16'h0005,
                                    16'h0004, 16'h0003, 16'h0002, 16'h0001};

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          is_store;
  logic [15:0]   base;
  logic [15:0]   stride;
  logic [4:0]    count;
  logic [127:0]  st_data;
  logic          busy;
  logic          done;
  logic [127:0]  ld_data;
  logic [15:0]   pos1, pos2, pos3;
  logic [15:0]   WD1, WD2, WD3;
  logic          OE;
  logic          wEnable;
  logic [15:0]   RD1, RD2, RD3;

  logic [15:0]   mem [0:65535];

  int n_checks = 0;
  int n_fail = 0;

  int            done_at;
  int            nbeats;
  int            noe;
  int            nwe;
  logic [15:0]   bp1 [8];
  logic [15:0]   bp2 [8];
  logic [15:0]   bp3 [8];
  logic [15:0]   bw1 [8];
  logic [15:0]   bw2 [8];
  logic [15:0]   bw3 [8];
  int            bcyc [8];
  logic [127:0]  ld_at_done;
  logic [15:0]   we_m, dn_m, by_m;
  int            qcnt;

  vector_lsu #(.NUM_LANES(NL), .MEM_RD_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_store(is_store),
    .base(base), .stride(stride), .count(count), .st_data(st_data),
    .busy(busy), .done(done), .ld_data(ld_data),
    .pos1(pos1), .pos2(pos2), .pos3(pos3),
    .WD1(WD1), .WD2(WD2), .WD3(WD3),
    .OE(OE), .wEnable(wEnable),
    .RD1(RD1), .RD2(RD2), .RD3(RD3)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Three-port memory with one-cycle registered read
  always @(posedge clock) begin
    if (wEnable) begin
      mem[pos1] <= WD1;
      mem[pos2] <= WD2;
      mem[pos3] <= WD3;
    end
    if (OE) begin
      RD1 <= mem[pos1];
      RD2 <= mem[pos2];
      RD3 <= mem[pos3];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of an IDLE cycle T; returns at the negedge of T+1
  task automatic issue(input logic st, input logic [15:0] b, input logic [15:0] s,
                       input logic [4:0] c, input logic [127:0] d);
    is_store = st;
    base     = b;
    stride   = s;
    count    = c;
    st_data  = d;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  // Records beats until done (bounded), then steps into the following IDLE cycle
  task automatic collect();
    done_at = -1;
    nbeats  = 0;
    noe     = 0;
    nwe     = 0;
    for (int n = 1; n <= 40; n++) begin
      if (OE) noe++;
      if (wEnable) nwe++;
      if (OE || wEnable) begin
        if (nbeats < 8) begin
          bp1[nbeats]  = pos1;
          bp2[nbeats]  = pos2;
          bp3[nbeats]  = pos3;
          bw1[nbeats]  = WD1;
          bw2[nbeats]  = WD2;
          bw3[nbeats]  = WD3;
          bcyc[nbeats] = n;
        end
        nbeats++;
      end
      if (done) begin
        done_at    = n;
        ld_at_done = ld_data;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  // Directed stimulus sequence
  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    is_store = 1'b0;
    base     = 16'd0;
    stride   = 16'd1;
    count    = 5'd0;
    st_data  = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_oe", OE, 1'b0);
    check("rst_we", wEnable, 1'b0);
    check("rst_pos", {pos1, pos2, pos3}, 48'd0);
    check("rst_wd", {WD1, WD2, WD3}, 48'd0);
    check("rst_ld", ld_data, 128'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Unit-stride store of eight lanes
    issue(1'b1, 16'h0000, 16'h0001, 5'd8, DATA8);
    collect();
    check("st_beats", nbeats, 3);
    check("st_done_at", done_at, 4);
    check("st_no_oe", noe, 0);
    check("st_cycles", bcyc[0] * 100 + bcyc[1] * 10 + bcyc[2], 123);
    check("st_b0_pos", {bp1[0], bp2[0], bp3[0]}, {16'd0, 16'd1, 16'd2});
    check("st_b0_wd", {bw1[0], bw2[0], bw3[0]}, {16'd1, 16'd2, 16'd3});
    check("st_b1_pos", {bp1[1], bp2[1], bp3[1]}, {16'd3, 16'd4, 16'd5});
    check("st_b2_pos", {bp1[2], bp2[2], bp3[2]}, {16'd6, 16'd7, 16'd7});
    check("st_b2_wd", {bw1[2], bw2[2], bw3[2]}, {16'd7, 16'd8, 16'd8});

    // Load the same eight lanes back
    issue(1'b0, 16'h0000, 16'h0001, 5'd8, 128'd0);
    collect();
    check("ld_beats", noe, 3);
    check("ld_no_we", nwe, 0);
    check("ld_oe_cycles", bcyc[0] * 100 + bcyc[1] * 10 + bcyc[2], 123);
    check("ld_done_at", done_at, 5);
    check("ld_data", ld_at_done, DATA8);

    // Two-lane load: lanes 2..7 keep the earlier result
    issue(1'b0, 16'h0005, 16'h0001, 5'd2, 128'd0);
    collect();
    check("pl_beats", nbeats, 1);
    check("pl_done_at", done_at, 3);
    check("pl_pos", {bp1[0], bp2[0], bp3[0]}, {16'd5, 16'd6, 16'd6});
    check("pl_data", ld_at_done, {16'h0008, 16'h0007, 16'h0006, 16'h0005,
                                  16'h0004, 16'h0003, 16'h0007, 16'h0006});

    // count=0 finishes at once with no memory traffic
    issue(1'b1, 16'h0000, 16'h0001, 5'd0, DATA8);
    collect();
    check("c0_done_at", done_at, 1);
    check("c0_beats", nbeats, 0);

    // count=20 is clamped to eight lanes
    issue(1'b1, 16'h0000, 16'h0001, 5'd20, DATA8);
    collect();
    check("cl_beats", nbeats, 3);
    check("cl_done_at", done_at, 4);
    check("cl_b2_pos", {bp1[2], bp2[2], bp3[2]}, {16'd6, 16'd7, 16'd7});

    // Address wrap at the top of the address space
    issue(1'b0, 16'hFFFE, 16'h0004, 5'd3, 128'd0);
    collect();
    check("sw_beats", nbeats, 1);
    check("sw_done_at", done_at, 3);
`ifdef VLSU_STRIDE_EN
    check("sw_pos", {bp1[0], bp2[0], bp3[0]}, {16'hFFFE, 16'h0002, 16'h0006});
`else
    check("sw_pos", {bp1[0], bp2[0], bp3[0]}, {16'hFFFE, 16'hFFFF, 16'h0000});
`endif

    // start held high: the second command is accepted only in IDLE after done
    is_store = 1'b1;
    base     = 16'h0000;
    stride   = 16'h0001;
    count    = 5'd8;
    st_data  = DATA8;
    start    = 1'b1;
    we_m = 16'd0;
    dn_m = 16'd0;
    by_m = 16'd0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (wEnable) we_m[n] = 1'b1;
      if (done) dn_m[n] = 1'b1;
      if (busy) by_m[n] = 1'b1;
      if (n == 10) start = 1'b0;
    end
    check("bb_we_mask", we_m, 16'h01CE);
    check("bb_done_mask", dn_m, 16'h0210);
    check("bb_busy_mask", by_m, 16'h01CE);

    // Reset in the middle of a store abandons it
    issue(1'b1, 16'h0000, 16'h0001, 5'd8, DATA8);
    check("mr_first_beat", wEnable, 1'b1);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("mr_we", wEnable, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_done", done, 1'b0);
    check("mr_pos", {pos1, pos2, pos3}, 48'd0);
    check("mr_wd", {WD1, WD2, WD3}, 48'd0);
    check("mr_ld", ld_data, 128'd0);
    reset_n = 1'b1;
    qcnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (wEnable || OE || done || busy) qcnt++;
    end
    check("mr_quiet", qcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
